mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one RAM port between instruction fetch (read-only)
//               and the memory-op data stage (read/write). Each access runs
//               issue -> wait for ram_ack -> respond. Data has fixed
//               priority; fetch is guaranteed a grant after STARVE_LIMIT
//               consecutive losses; accesses never acknowledged abort after
//               TIMEOUT cycles with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,    // 1..15
    parameter int TIMEOUT      = 16    // 1..255
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_rdata,
    output logic        f_done,
    output logic        f_err,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    // RAM port
    output logic [31:0] ram_r_addr,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_w_line,
    output logic        ram_r,
    output logic        ram_w,
    input  logic [31:0] ram_r_line,
    input  logic        ram_ack
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic [7:0] c_tmo_last     = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner_fetch;   // 0 = data port owns the access, 1 = fetch
    logic [3:0]  r_starve_cnt;    // consecutive arbitrations fetch has lost
    logic [7:0]  r_tmo_cnt;       // cycles spent waiting in ACCESS

    // Fetch takes the grant when it is alone or has been passed over enough.
    logic w_fetch_wins;
    assign w_fetch_wins = f_req & (~d_req | (r_starve_cnt == c_starve_limit));

    // Arbitration, RAM handshake sequencing and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner_fetch <= 1'b0;
            r_starve_cnt  <= 4'd0;
            r_tmo_cnt     <= 8'd0;
            f_rdata       <= 32'd0;
            f_done        <= 1'b0;
            f_err         <= 1'b0;
            d_rdata       <= 32'd0;
            d_done        <= 1'b0;
            d_err         <= 1'b0;
            ram_r_addr    <= 32'd0;
            ram_w_addr    <= 32'd0;
            ram_w_line    <= 32'd0;
            ram_r         <= 1'b0;
            ram_w         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (d_req || f_req) begin
                        if (w_fetch_wins) begin
                            r_owner_fetch <= 1'b1;
                            r_starve_cnt  <= 4'd0;
                            ram_r         <= 1'b1;
                            ram_r_addr    <= f_addr;
                        end else begin
                            r_owner_fetch <= 1'b0;
                            if (f_req && (r_starve_cnt != c_starve_limit)) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                            if (d_we) begin
                                ram_w      <= 1'b1;
                                ram_w_addr <= d_addr;
                                ram_w_line <= d_wdata;
                            end else begin
                                ram_r      <= 1'b1;
                                ram_r_addr <= d_addr;
                            end
                        end
                        r_tmo_cnt <= 8'd0;
                        r_state   <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    // An acknowledge arriving on the last allowed cycle still
                    // completes cleanly, so it is tested first.
                    if (ram_ack) begin
                        ram_r <= 1'b0;
                        ram_w <= 1'b0;
                        if (r_owner_fetch) begin
                            f_done <= 1'b1;
                            f_err  <= 1'b0;
                            if (ram_r) begin
                                f_rdata <= ram_r_line;
                            end
                        end else begin
                            d_done <= 1'b1;
                            d_err  <= 1'b0;
                            if (ram_r) begin
                                d_rdata <= ram_r_line;
                            end
                        end
                        r_state <= ST_RESP;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        ram_r <= 1'b0;
                        ram_w <= 1'b0;
                        if (r_owner_fetch) begin
                            f_done  <= 1'b1;
                            f_err   <= 1'b1;
                            f_rdata <= 32'd0;
                        end else begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                        end
                        r_state <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Requests are deliberately not sampled here so a
                    // requester dropping req at its done edge is not reissued.
                    f_done  <= 1'b0;
                    f_err   <= 1'b0;
                    d_done  <= 1'b0;
                    d_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int SL  = 2;   // starvation limit used for the DUT
    localparam int TMO = 8;   // timeout used for the DUT
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic [31:0] f_rdata;
    logic        f_done, f_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done, d_err;
    logic [31:0] ram_r_addr, ram_w_addr, ram_w_line;
    logic        ram_r, ram_w;
    logic [31:0] ram_r_line = '0;
    logic        ram_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    // RAM responder controls
    int          ack_lat  = NEVER;  // 0 = ack in first ACCESS cycle
    int          age      = 0;      // cycles the current strobe has been high
    bit          rand_lat = 1'b0;
    bit          rand_line = 1'b0;
    logic [31:0] fixed_line = '0;

    wire [165:0] all_out = {f_rdata, f_done, f_err, d_rdata, d_done, d_err,
                            ram_r_addr, ram_w_addr, ram_w_line, ram_r, ram_w};

    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_line(ram_w_line),
        .ram_r(ram_r), .ram_w(ram_w), .ram_r_line(ram_r_line), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    // Advance one cycle, sample after the edge, and play the RAM for this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ram_r || ram_w) age = age + 1;
        else age = 0;
        if (age == 1 && rand_lat)
            ack_lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
        ram_ack    = (ram_r || ram_w) && (age == ack_lat + 1);
        ram_r_line = rand_line ? $urandom() : fixed_line;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_data_read();
        ack_lat = 1; fixed_line = 32'hDEADBEEF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        tick();
        checks++;
        if ({ram_r, ram_w, ram_r_addr} !== {1'b1, 1'b0, 32'h10}) begin
            errors++; $display("FAIL rd_issue: got r=%b w=%b a=%h expected r=1 w=0 a=10", ram_r, ram_w, ram_r_addr);
        end
        tick();
        checks++;
        if ({ram_r, ram_r_addr, d_done} !== {1'b1, 32'h10, 1'b0}) begin
            errors++; $display("FAIL rd_hold: got r=%b a=%h done=%b expected r=1 a=10 done=0", ram_r, ram_r_addr, d_done);
        end
        tick();
        checks++;
        if ({ram_r, d_done, d_err, d_rdata, f_done} !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL rd_done: got r=%b done=%b err=%b rdata=%h fdone=%b expected 0 1 0 deadbeef 0",
                               ram_r, d_done, d_err, d_rdata, f_done);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if ({d_done, d_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rd_after: got done=%b rdata=%h expected 0 deadbeef", d_done, d_rdata);
        end
    endtask

    task automatic test_data_write();
        ack_lat = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        tick();
        checks++;
        if ({ram_w, ram_r, ram_w_addr, ram_w_line, d_done} !== {1'b1, 1'b0, 32'h20, 32'h12345678, 1'b0}) begin
            errors++; $display("FAIL wr_issue: got w=%b r=%b a=%h l=%h done=%b expected 1 0 20 12345678 0",
                               ram_w, ram_r, ram_w_addr, ram_w_line, d_done);
        end
        tick();
        checks++;
        if ({ram_w, ram_r, d_done, d_err} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_done: got w=%b r=%b done=%b err=%b expected 0 0 1 0", ram_w, ram_r, d_done, d_err);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        ack_lat = 0; fixed_line = 32'hCAFEF00D;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        f_req = 1'b1; f_addr = 32'h34;
        tick();
        checks++;
        if ({ram_r, ram_r_addr} !== {1'b1, 32'h30}) begin
            errors++; $display("FAIL sim_first: got r=%b a=%h expected r=1 a=30", ram_r, ram_r_addr);
        end
        tick();
        checks++;
        if ({d_done, f_done, d_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
            errors++; $display("FAIL sim_ddone: got d=%b f=%b rdata=%h expected 1 0 cafef00d", d_done, f_done, d_rdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if ({ram_r, ram_w, f_done} !== 3'b000) begin
            errors++; $display("FAIL sim_idle: got r=%b w=%b f=%b expected 0 0 0", ram_r, ram_w, f_done);
        end
        tick();
        checks++;
        if ({ram_r, ram_r_addr} !== {1'b1, 32'h34}) begin
            errors++; $display("FAIL sim_fissue: got r=%b a=%h expected r=1 a=34", ram_r, ram_r_addr);
        end
        tick();
        checks++;
        if ({f_done, f_err, f_rdata, d_done} !== {1'b1, 1'b0, 32'hCAFEF00D, 1'b0}) begin
            errors++; $display("FAIL sim_fdone: got f=%b err=%b rdata=%h d=%b expected 1 0 cafef00d 0",
                               f_done, f_err, f_rdata, d_done);
        end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int exp_order[6] = '{0, 0, 1, 0, 0, 1};
        int grants = 0;
        bit prev_strobe = 1'b0;
        bit got_f;
        bit seen;
        ack_lat = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        f_req = 1'b1; f_addr = 32'h80;
        for (int i = 0; i < 80 && grants < 6; i++) begin
            tick();
            if ((ram_r || ram_w) && !prev_strobe) begin
                got_f = (ram_r_addr == 32'h80);
                checks++;
                if (int'(got_f) != exp_order[grants]) begin
                    errors++; $display("FAIL starve_grant%0d: got fetch=%0d expected fetch=%0d", grants, got_f, exp_order[grants]);
                end
                grants++;
            end
            if (d_done) d_addr = d_addr + 32'd4;
            prev_strobe = ram_r || ram_w;
        end
        checks++;
        if (grants != 6) begin
            errors++; $display("FAIL starve_count: got %0d grants expected 6", grants);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = f_done;
        end
        d_req = 1'b0; f_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int hi = 0;
        bit seen = 1'b0;
        ack_lat = NEVER;
        f_req = 1'b1; f_addr = 32'h40;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (ram_r) hi++;
            seen = f_done;
        end
        checks++;
        if ({seen, f_err, f_rdata, ram_r} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL tmo_done: got done=%b err=%b rdata=%h r=%b expected 1 1 0 0", seen, f_err, f_rdata, ram_r);
        end
        checks++;
        if (hi != TMO) begin
            errors++; $display("FAIL tmo_len: got %0d strobe cycles expected %0d", hi, TMO);
        end
        f_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({f_done, f_err, ram_r, ram_w} !== 4'b0000) begin
            errors++; $display("FAIL tmo_idle: got done=%b err=%b r=%b w=%b expected 0 0 0 0", f_done, f_err, ram_r, ram_w);
        end
    endtask

    task automatic test_reset_midop();
        ack_lat = NEVER;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'hA5A5A5A5;
        tick();
        tick();
        tick();
        checks++;
        if (ram_w !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got w=%b expected 1", ram_w);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got %h expected 0", all_out);
        end
        rst = 1'b0;
        ack_lat = 0;
        tick();
        checks++;
        if ({ram_w, ram_w_addr, ram_w_line, d_done} !== {1'b1, 32'h50, 32'hA5A5A5A5, 1'b0}) begin
            errors++; $display("FAIL rstmid_reissue: got w=%b a=%h l=%h done=%b expected 1 50 a5a5a5a5 0",
                               ram_w, ram_w_addr, ram_w_line, d_done);
        end
        tick();
        checks++;
        if ({d_done, d_err} !== 2'b10) begin
            errors++; $display("FAIL rstmid_done: got done=%b err=%b expected 1 0", d_done, d_err);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    // Randomized traffic checked against a transaction-level model.
    task automatic test_random();
        bit          m_busy = 1'b0, m_own_f = 1'b0, m_read = 1'b0, m_drd_known = 1'b1;
        int          m_done_at = 0, m_last_done = -10, m_losses = 0;
        logic [31:0] m_frd = '0, m_drd = '0, m_cap = '0;
        bit          prev_d = 1'b0, prev_f = 1'b0, prev_strobe = 1'b0;
        bit          strobe, rise, exp_grant, win_f, timed_out;
        logic [3:0]  exp_flags;
        rst = 1'b1; d_req = 1'b0; f_req = 1'b0;
        tick();
        rst = 1'b0;
        rand_lat = 1'b1; rand_line = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            tick();
            strobe = ram_r || ram_w;
            rise   = strobe && !prev_strobe;
            exp_grant = !m_busy && (c - 1 > m_last_done) && (prev_d || prev_f);
            checks++;
            if (rise !== exp_grant) begin
                errors++; $display("FAIL rnd_grant c=%0d: got rise=%b expected %b", c, rise, exp_grant);
            end
            if (exp_grant) begin
                win_f = prev_f && (!prev_d || m_losses >= SL);
                if (win_f) m_losses = 0;
                else if (prev_f && m_losses < SL) m_losses++;
                m_busy = 1'b1; m_own_f = win_f;
                m_read = win_f || !d_we;
                m_done_at = (ack_lat >= NEVER) ? c + TMO : c + ack_lat + 1;
                checks++;
                if (win_f) begin
                    if ({ram_r, ram_w, ram_r_addr} !== {1'b1, 1'b0, f_addr}) begin
                        errors++; $display("FAIL rnd_fissue c=%0d: got r=%b w=%b a=%h expected 1 0 %h", c, ram_r, ram_w, ram_r_addr, f_addr);
                    end
                end else if (d_we) begin
                    if ({ram_r, ram_w, ram_w_addr, ram_w_line} !== {1'b0, 1'b1, d_addr, d_wdata}) begin
                        errors++; $display("FAIL rnd_wissue c=%0d: got r=%b w=%b a=%h l=%h expected 0 1 %h %h",
                                           c, ram_r, ram_w, ram_w_addr, ram_w_line, d_addr, d_wdata);
                    end
                end else begin
                    if ({ram_r, ram_w, ram_r_addr} !== {1'b1, 1'b0, d_addr}) begin
                        errors++; $display("FAIL rnd_dissue c=%0d: got r=%b w=%b a=%h expected 1 0 %h", c, ram_r, ram_w, ram_r_addr, d_addr);
                    end
                end
            end
            checks++;
            if (strobe !== (m_busy && c < m_done_at) || (ram_r && ram_w)) begin
                errors++; $display("FAIL rnd_strobe c=%0d: got r=%b w=%b expected active=%b", c, ram_r, ram_w, m_busy && c < m_done_at);
            end
            if (ram_ack) m_cap = ram_r_line;
            exp_flags = 4'b0000;
            if (m_busy && c == m_done_at) begin
                timed_out = (m_done_at - (c - 0) == 0) && (ack_lat >= NEVER);
                exp_flags = m_own_f ? {1'b1, timed_out, 2'b00} : {2'b00, 1'b1, timed_out};
                if (m_own_f) m_frd = timed_out ? 32'd0 : m_cap;
                else if (timed_out) begin m_drd = 32'd0; m_drd_known = 1'b1; end
                else if (m_read) begin m_drd = m_cap; m_drd_known = 1'b1; end
                else m_drd_known = 1'b0;
                m_busy = 1'b0; m_last_done = c;
            end
            checks++;
            if ({f_done, f_err, d_done, d_err} !== exp_flags) begin
                errors++; $display("FAIL rnd_done c=%0d: got fd/fe/dd/de=%b expected %b", c, {f_done, f_err, d_done, d_err}, exp_flags);
            end
            checks++;
            if (f_rdata !== m_frd || (m_drd_known && d_rdata !== m_drd)) begin
                errors++; $display("FAIL rnd_rdata c=%0d: got f=%h d=%h expected f=%h d=%h", c, f_rdata, d_rdata, m_frd, m_drd);
            end
            // requester behaviour: drop on own done, randomly raise new requests
            if (f_done) f_req = 1'b0;
            if (d_done) d_req = 1'b0;
            if (!f_req && $urandom_range(0, 1) == 1) begin
                f_req = 1'b1; f_addr = $urandom();
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
            end
            prev_d = d_req; prev_f = f_req; prev_strobe = strobe;
        end
        rand_lat = 1'b0; rand_line = 1'b0;
        d_req = 1'b0; f_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
